// File: rtl/ahb_master_arbiter_pkg.sv
// ahb_arb_pkg: shared FSM/owner enums and AHB transfer-type codes for ahb_master_arbiter
package ahb_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_RD, OWN_WR} owner_t;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
endpackage

// File: rtl/ahb_master_arbiter_if.sv
// ahb_master_arbiter_if: AHB-Lite single-master bus signals with master/slave views
interface ahb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  modport master(output haddr, htrans, hwrite, hwdata, input hrdata, hready);
  modport slave(input haddr, htrans, hwrite, hwdata, output hrdata, hready);
endinterface

// File: rtl/ahb_master_arbiter_arb_rr2.sv
// arb_rr2: 2-way round-robin picker; the pointer moves to the channel that did not win
module arb_rr2
  import ahb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  owner_t ptr;
  // pointer's channel wins a tie, a lone requester always wins
  always_comb gnt = ptr == OWN_WR ? {req[1], req[0] & !req[1]} : {req[1] & !req[0], req[0]};
  // after each grant favour the loser next time
  always_ff @(posedge clk)
    if (rst) ptr <= OWN_RD;
    else if (advance) ptr <= gnt[0] ? OWN_WR : OWN_RD;
endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: shares one AHB-Lite master port between read and write channels; define ARB_WRITE_PRIO_EN for fixed write priority
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_gnt,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_gnt,
  output logic                 wr_done,
  output logic                 err,
  output logic                 busy,
  ahb_master_arbiter_if.master ahb
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, state_n;
  owner_t own;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [CW-1:0] cnt;
  logic [1:0] req, gnt;
  logic launch, on_bus, stall, abort, fin;

  assign req = state == IDLE && !halt ? {wr_req, rd_req} : 2'b00;
`ifdef ARB_WRITE_PRIO_EN
  assign gnt = {req[1], req[0] & !req[1]};
`else
  arb_rr2 u_arb (.clk(clk), .rst(rst), .req(req), .advance(|req), .gnt(gnt));
`endif

  // first ADDR cycle only puts the address phase on the bus; hready counts from the next cycle
  always_comb begin
    launch = state == ADDR && ahb.htrans == HTRANS_IDLE;
    on_bus = state == DATA || (state == ADDR && !launch);
    stall = on_bus && !ahb.hready;
    abort = stall && TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    fin = state == DATA && ahb.hready;
    state_n = abort ? IDLE : |gnt ? ADDR : on_bus && ahb.hready ? (state == ADDR ? DATA : IDLE) : state;
  end

  // state, latched request, stall counter and every registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own <= OWN_RD;
      lat_addr <= '0;
      lat_data <= '0;
      cnt <= '0;
      rd_gnt <= 1'b0;
      wr_gnt <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      wr_done <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      ahb.haddr <= '0;
      ahb.htrans <= HTRANS_IDLE;
      ahb.hwrite <= 1'b0;
      ahb.hwdata <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      rd_gnt <= gnt[0];
      wr_gnt <= gnt[1];
      rd_valid <= fin && own == OWN_RD;
      wr_done <= fin && own == OWN_WR;
      err <= abort;
      cnt <= stall && !abort ? cnt + 1'b1 : '0;
      if (|gnt) begin
        own <= gnt[1] ? OWN_WR : OWN_RD;
        lat_addr <= gnt[1] ? wr_addr : rd_addr;
        lat_data <= wr_data;
      end
      if (fin && own == OWN_RD) rd_data <= ahb.hrdata;
      if (launch) begin
        ahb.haddr <= lat_addr;
        ahb.hwrite <= own == OWN_WR;
      end
      ahb.htrans <= launch ? HTRANS_NONSEQ : state_n == ADDR ? ahb.htrans : HTRANS_IDLE;
      if (state == ADDR && on_bus && ahb.hready && own == OWN_WR) ahb.hwdata <= lat_data;
    end
  end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed vectors, corner sequences and a random run against a transaction-level model
module tb_ahb_master_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst, halt, rd_req, rd_gnt, rd_valid, wr_req, wr_gnt, wr_done, err, busy;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
  int checks = 0, errors = 0;
  int n, ns, rv, pct;
  logic seen;

  ahb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .err(err), .busy(busy), .ahb(bus)
  );

  always #5 clk = ~clk;

  // transaction model: one transfer at a time, last winner remembered for fairness
  logic m_act, m_dir, last;
  int m_phase, m_stall;
  logic [31:0] m_addr, m_data;
  logic e_rd_gnt, e_wr_gnt, e_rd_valid, e_wr_done, e_err, e_busy, e_hwrite;
  logic [1:0] e_htrans;
  logic [31:0] e_haddr, e_hwdata, e_rd_data;

  task automatic model();
    logic w;
    {e_rd_gnt, e_wr_gnt, e_rd_valid, e_wr_done, e_err} = '0;
    if (rst) begin
      {m_act, e_busy, e_hwrite} = '0;
      last = 1'b1;
      m_phase = 0;
      m_stall = 0;
      e_htrans = 2'b00;
      e_haddr = '0;
      e_hwdata = '0;
      e_rd_data = '0;
    end else if (!m_act) begin
      if (!halt && (rd_req || wr_req)) begin
`ifdef ARB_WRITE_PRIO_EN
        w = wr_req;
`else
        w = (rd_req && wr_req) ? !last : wr_req;
`endif
        last = w;
        m_act = 1'b1;
        m_dir = w;
        m_addr = w ? wr_addr : rd_addr;
        m_data = wr_data;
        m_phase = 0;
        m_stall = 0;
        if (w) e_wr_gnt = 1'b1;
        else e_rd_gnt = 1'b1;
      end
    end else if (m_phase == 0) begin
      e_htrans = 2'b10;
      e_haddr = m_addr;
      e_hwrite = m_dir;
      m_phase = 1;
    end else if (bus.hready) begin
      m_stall = 0;
      if (m_phase == 1) begin
        e_htrans = 2'b00;
        if (m_dir) e_hwdata = m_data;
        m_phase = 2;
      end else begin
        m_act = 1'b0;
        if (m_dir) e_wr_done = 1'b1;
        else begin
          e_rd_valid = 1'b1;
          e_rd_data = bus.hrdata;
        end
      end
    end else begin
      m_stall++;
      if (m_stall == TO) begin
        e_err = 1'b1;
        e_htrans = 2'b00;
        m_act = 1'b0;
      end
    end
    e_busy = m_act;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check();
    chk("rd_gnt", rd_gnt, e_rd_gnt);
    chk("wr_gnt", wr_gnt, e_wr_gnt);
    chk("rd_valid", rd_valid, e_rd_valid);
    chk("wr_done", wr_done, e_wr_done);
    chk("err", err, e_err);
    chk("busy", busy, e_busy);
    chk("htrans", bus.htrans, e_htrans);
    chk("haddr", bus.haddr, e_haddr);
    chk("hwrite", bus.hwrite, e_hwrite);
    chk("hwdata", bus.hwdata, e_hwdata);
    chk("rd_data", rd_data, e_rd_data);
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    @(negedge clk);
    check();
  endtask

  typedef struct {
    logic rd, wr, rdy;
    logic gr, gw, nsq, rvl, wdn, bsy;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 0, 1, 1, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 0, 1, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    rst = 1'b1; halt = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = 32'h100; wr_addr = 32'h30D40; wr_data = 32'h00FF00FF;
    bus.hready = 1'b1; bus.hrdata = 32'hDEADBEEF;
    cyc();
    cyc();
    chk("reset_busy", busy, 1'b0);
    chk("reset_htrans", bus.htrans, 2'b00);
    rst = 1'b0;
    // single read then a write with two wait states in its data phase
    for (int i = 0; i < 12; i++) begin
      rd_req = tbl[i].rd;
      wr_req = tbl[i].wr;
      bus.hready = tbl[i].rdy;
      cyc();
      chk($sformatf("tbl%0d_rd_gnt", i), rd_gnt, tbl[i].gr);
      chk($sformatf("tbl%0d_wr_gnt", i), wr_gnt, tbl[i].gw);
      chk($sformatf("tbl%0d_nonseq", i), bus.htrans == 2'b10, tbl[i].nsq);
      chk($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].rvl);
      chk($sformatf("tbl%0d_wr_done", i), wr_done, tbl[i].wdn);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      if (i == 3) chk("tbl_rd_data", rd_data, 32'hDEADBEEF);
      if (i >= 7 && i <= 9) chk($sformatf("tbl%0d_hwdata", i), bus.hwdata, 32'h00FF00FF);
    end
    // both requesting continuously
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1; bus.hready = 1'b1; n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      cyc();
      if (rd_gnt || wr_gnt) begin
`ifdef ARB_WRITE_PRIO_EN
        chk($sformatf("arb_grant%0d", n), wr_gnt, 1'b1);
`else
        chk($sformatf("arb_grant%0d", n), wr_gnt, n % 2);
`endif
        n++;
      end
    end
    chk("arb_count", n, 8);
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (6) cyc();
    // hready stuck low until the timeout fires
    rd_req = 1'b1; bus.hready = 1'b0;
    cyc();
    rd_req = 1'b0; ns = 0; rv = 0; seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      cyc();
      if (bus.htrans == 2'b10) ns++;
      if (rd_valid) rv++;
      if (err) begin
        seen = 1'b1;
        chk("to_busy", busy, 1'b0);
        chk("to_htrans", bus.htrans, 2'b00);
      end
    end
    chk("to_err_seen", seen, 1'b1);
    chk("to_stall_cycles", ns, TO);
    chk("to_no_valid", rv, 0);
    bus.hready = 1'b1;
    cyc();
    chk("to_err_once", err, 1'b0);
    rd_req = 1'b1; seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cyc();
      if (rd_gnt) rd_req = 1'b0;
      if (rd_valid) seen = 1'b1;
    end
    chk("to_next_served", seen, 1'b1);
    repeat (2) cyc();
    // halt raised while a read is in its data phase
    rd_req = 1'b1; bus.hready = 1'b1;
    cyc();
    rd_req = 1'b0;
    cyc();
    cyc();
    halt = 1'b1; wr_req = 1'b1; bus.hready = 1'b0;
    cyc();
    bus.hready = 1'b1;
    cyc();
    chk("halt_rd_valid", rd_valid, 1'b1);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (wr_gnt) n++;
    end
    chk("halt_no_wr_gnt", n, 0);
    halt = 1'b0; seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      cyc();
      if (wr_gnt) seen = 1'b1;
    end
    chk("halt_release_gnt", seen, 1'b1);
    wr_req = 1'b0;
    repeat (6) cyc();
    // reset in the middle of an address phase
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0; bus.hready = 1'b0;
    cyc();
    chk("rst_in_addr", bus.htrans, 2'b10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_htrans", bus.htrans, 2'b00);
    chk("rst_haddr", bus.haddr, 32'h0);
    rd_req = 1'b1; wr_req = 1'b1; bus.hready = 1'b1;
    cyc();
`ifdef ARB_WRITE_PRIO_EN
    chk("rst_ptr_read", wr_gnt, 1'b1);
`else
    chk("rst_ptr_read", rd_gnt, 1'b1);
`endif
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (6) cyc();
    // randomized traffic, stalls, halts and occasional reset
    pct = 95;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) pct = $urandom_range(0, 1) ? 95 : 55;
      bus.hready = $urandom_range(0, 99) < pct;
      bus.hrdata = $urandom;
      halt = $urandom_range(0, 9) == 0 ? ~halt : halt;
      rst = $urandom_range(0, 499) == 0;
      if (!rd_req && $urandom_range(0, 3) == 0) begin
        rd_req = 1'b1;
        rd_addr = $urandom;
      end
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req = 1'b1;
        wr_addr = $urandom;
        wr_data = $urandom;
      end
      cyc();
      if (rd_gnt) rd_req = 1'b0;
      if (wr_gnt) wr_req = 1'b0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
